// File: rtl/i2c_master_slave_pair.sv
// i2c_master_slave_pair
// A single-byte I2C master and a single-register I2C slave sharing one
// open-drain SDA/SCL bus. The host asks for one-byte writes or reads. The
// slave answers SLAVE_ADDR only. It stores written bytes and returns the
// stored byte on reads.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-low reset
//   addr     in   7-bit target address, latched at transaction start
//   data_in  in   write byte, latched at transaction start
//   enable   in   start request, honoured only while ready=1
//   rw       in   direction, latched at transaction start (0 write, 1 read)
//   data_out out  last byte read successfully
//   ready    out  idle and able to accept enable
//   i2c_sda  io   open-drain data line (pulled up internally)
//   i2c_scl  io   open-drain clock line (pulled up internally)
//
// Handshake: a transaction is accepted on the clk edge where enable=1 and
// ready=1. ready stays low until the edge on which STOP completes.

module i2c_master_slave_pair #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = 7'b0101010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);

    localparam int             CW   = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);

    typedef enum logic [3:0] {
        M_IDLE, M_START, M_ADDR, M_ADDR_ACK, M_WDATA,
        M_WACK, M_RDATA, M_RNACK, M_STOP
    } m_state_e;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA
    } s_state_e;

    // ---------------- bus ----------------
    logic m_scl_low_q, m_sda_low_q, s_sda_low_q;

    pullup (i2c_sda);
    pullup (i2c_scl);
    assign i2c_sda = (m_sda_low_q || s_sda_low_q) ? 1'b0 : 1'bz;
    assign i2c_scl = m_scl_low_q ? 1'b0 : 1'bz;

    // ---------------- master ----------------
    m_state_e      m_state_q;
    logic [CW-1:0] m_cnt_q;     // position inside the current SCL period
    logic [2:0]    m_bit_q;
    logic [7:0]    m_shift_q;
    logic [7:0]    m_wdata_q;
    logic          m_rw_q;
    logic          m_rd_ok_q;
    logic          ready_q;
    logic [7:0]    data_out_q;
    logic          m_tx_low;

    assign ready    = ready_q;
    assign data_out = data_out_q;

    // The master drives a data bit only in ADDR and WDATA. It releases SDA in every other bit slot.
    always_comb begin
        m_tx_low = 1'b0;
        if ((m_state_q == M_ADDR) || (m_state_q == M_WDATA))
            m_tx_low = ~m_shift_q[7];
    end

    // Each period is SCL low for cnt < HALF and high for the rest.
    // SDA is held on cnt 0, so it changes one clk after SCL falls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_state_q   <= M_IDLE;
            m_cnt_q     <= '0;
            m_bit_q     <= 3'd0;
            m_shift_q   <= 8'h00;
            m_wdata_q   <= 8'h00;
            m_rw_q      <= 1'b0;
            m_rd_ok_q   <= 1'b0;
            m_scl_low_q <= 1'b0;
            m_sda_low_q <= 1'b0;
            ready_q     <= 1'b1;
            data_out_q  <= 8'h00;
        end else begin
            case (m_state_q)
                M_IDLE: begin
                    m_scl_low_q <= 1'b0;
                    m_sda_low_q <= 1'b0;
                end
                M_START: begin
                    m_scl_low_q <= (m_cnt_q >= HALF);
                    m_sda_low_q <= 1'b1;
                end
                M_STOP: begin
                    m_scl_low_q <= (m_cnt_q < HALF);
                    if (m_cnt_q != '0) m_sda_low_q <= (m_cnt_q != LAST);
                end
                default: begin
                    m_scl_low_q <= (m_cnt_q < HALF);
                    if (m_cnt_q != '0) m_sda_low_q <= m_tx_low;
                end
            endcase

            if (m_state_q == M_IDLE) begin
                m_cnt_q <= '0;
                if (enable) begin
                    m_shift_q <= {addr, rw};
                    m_wdata_q <= data_in;
                    m_rw_q    <= rw;
                    m_rd_ok_q <= 1'b0;
                    ready_q   <= 1'b0;
                    m_state_q <= M_START;
                end
            end else begin
                m_cnt_q <= (m_cnt_q == LAST) ? '0 : m_cnt_q + 1'b1;
                // End of an SCL period. SDA is sampled late in the high phase.
                if (m_cnt_q == LAST) begin
                    case (m_state_q)
                        M_START: begin
                            m_bit_q   <= 3'd7;
                            m_state_q <= M_ADDR;
                        end
                        M_ADDR, M_WDATA: begin
                            m_shift_q <= {m_shift_q[6:0], 1'b0};
                            m_bit_q   <= m_bit_q - 1'b1;
                            if (m_bit_q == 3'd0)
                                m_state_q <= (m_state_q == M_ADDR) ? M_ADDR_ACK : M_WACK;
                        end
                        M_ADDR_ACK: begin
                            m_bit_q <= 3'd7;
                            if (i2c_sda) begin
                                m_state_q <= M_STOP;
                            end else if (m_rw_q) begin
                                m_state_q <= M_RDATA;
                            end else begin
                                m_shift_q <= m_wdata_q;
                                m_state_q <= M_WDATA;
                            end
                        end
                        M_WACK:  m_state_q <= M_STOP;
                        M_RDATA: begin
                            m_shift_q <= {m_shift_q[6:0], i2c_sda};
                            m_bit_q   <= m_bit_q - 1'b1;
                            if (m_bit_q == 3'd0) m_state_q <= M_RNACK;
                        end
                        M_RNACK: begin
                            m_rd_ok_q <= 1'b1;
                            m_state_q <= M_STOP;
                        end
                        M_STOP: begin
                            if (m_rd_ok_q) data_out_q <= m_shift_q;
                            ready_q   <= 1'b1;
                            m_state_q <= M_IDLE;
                        end
                        default: m_state_q <= M_IDLE;
                    endcase
                end
            end
        end
    end

    // ---------------- slave ----------------
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= i2c_scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= i2c_sda;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  = ~scl_prev_q & scl_sync_q;
    assign scl_fall  = scl_prev_q & ~scl_sync_q;
    assign start_det = scl_prev_q & scl_sync_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_prev_q & scl_sync_q & ~sda_prev_q & sda_sync_q;

    s_state_e   s_state_q;
    logic [3:0] s_bit_q;
    logic [7:0] s_shift_q;
    logic       s_rw_q;
    logic [7:0] s_reg_q;

    // s_bit_q counts sampled bits when receiving. It counts driven bits when transmitting.
    // The slave acts on SCL falling edges, so its SDA changes only while SCL is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_state_q   <= S_IDLE;
            s_bit_q     <= 4'd0;
            s_shift_q   <= 8'h00;
            s_rw_q      <= 1'b0;
            s_reg_q     <= 8'h00;
            s_sda_low_q <= 1'b0;
        end else if (stop_det) begin
            s_state_q   <= S_IDLE;
            s_sda_low_q <= 1'b0;
        end else if (start_det) begin
            s_state_q   <= S_ADDR;
            s_bit_q     <= 4'd0;
            s_sda_low_q <= 1'b0;
        end else begin
            case (s_state_q)
                S_ADDR, S_WDATA: begin
                    if (scl_rise) begin
                        s_shift_q <= {s_shift_q[6:0], sda_sync_q};
                        s_bit_q   <= s_bit_q + 4'd1;
                    end else if (scl_fall && (s_bit_q == 4'd8)) begin
                        if (s_state_q == S_WDATA) begin
                            s_reg_q     <= s_shift_q;
                            s_sda_low_q <= 1'b1;
                            s_state_q   <= S_WACK;
                        end else if (s_shift_q[7:1] == SLAVE_ADDR) begin
                            s_rw_q      <= s_shift_q[0];
                            s_sda_low_q <= 1'b1;
                            s_state_q   <= S_ADDR_ACK;
                        end else begin
                            s_state_q <= S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (s_rw_q) begin
                            s_sda_low_q <= ~s_reg_q[7];
                            s_shift_q   <= {s_reg_q[6:0], 1'b0};
                            s_bit_q     <= 4'd1;
                            s_state_q   <= S_RDATA;
                        end else begin
                            s_sda_low_q <= 1'b0;
                            s_bit_q     <= 4'd0;
                            s_state_q   <= S_WDATA;
                        end
                    end
                end
                S_WACK: begin
                    if (scl_fall) begin
                        s_sda_low_q <= 1'b0;
                        s_state_q   <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (s_bit_q == 4'd8) begin
                            // Release for the master's NACK slot.
                            s_sda_low_q <= 1'b0;
                            s_state_q   <= S_IDLE;
                        end else begin
                            s_sda_low_q <= ~s_shift_q[7];
                            s_shift_q   <= {s_shift_q[6:0], 1'b0};
                            s_bit_q     <= s_bit_q + 4'd1;
                        end
                    end
                end
                default: s_sda_low_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_slave_pair.sv
// Bench for i2c_master_slave_pair: directed write/read transactions, wrong
// address, reset mid-transaction and enable held high across transactions.
// A bus monitor decodes the bits seen on SCL rising edges between START and
// STOP.

module tb_i2c_master_slave_pair;

    localparam int CLK_DIV  = 4;
    localparam int PER      = 2 * CLK_DIV;
    localparam int ACK_CYC  = 20 * PER;
    localparam int NACK_CYC = 11 * PER;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] data_in = 8'h00;
    logic       enable = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] data_out;
    logic       ready;
    wire        i2c_sda;
    wire        i2c_scl;

    int tests_run = 0;
    int tests_failed = 0;

    i2c_master_slave_pair #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'b0101010)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .enable   (enable),
        .rw       (rw),
        .data_out (data_out),
        .ready    (ready),
        .i2c_sda  (i2c_sda),
        .i2c_scl  (i2c_scl)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bus monitor ----------------
    logic mon_scl_q = 1'b1;
    logic mon_sda_q = 1'b1;
    logic bits_q[$];
    int   start_cnt = 0;
    int   stop_cnt = 0;

    always @(negedge clk) begin
        if (!mon_scl_q && i2c_scl) bits_q.push_back(i2c_sda);
        if (mon_scl_q && i2c_scl && mon_sda_q && !i2c_sda) begin
            start_cnt <= start_cnt + 1;
            bits_q.delete();
        end
        if (mon_scl_q && i2c_scl && !mon_sda_q && i2c_sda) stop_cnt <= stop_cnt + 1;
        mon_scl_q <= i2c_scl;
        mon_sda_q <= i2c_sda;
    end

    function automatic logic [7:0] get_byte(input int idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            if (idx + i < bits_q.size()) b[7-i] = bits_q[idx+i];
        return b;
    endfunction

    function automatic logic get_bit(input int idx);
        if (idx < bits_q.size()) return bits_q[idx];
        return 1'bx;
    endfunction

    // ---------------- driver ----------------
    // Pulses enable for one edge. Then it counts the clocks during which ready is low.
    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic r,
                           output int busy);
        @(posedge clk); #1;
        addr = a; data_in = d; rw = r; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        busy = 0;
        @(negedge clk);
        while (ready === 1'b0 && busy < 2000) begin
            busy++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ready); end
        tests_run++; if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        tests_run++; if (i2c_sda !== 1'b1) begin tests_failed++; $display("FAIL reset_sda: got %b want 1", i2c_sda); end
        tests_run++; if (i2c_scl !== 1'b1) begin tests_failed++; $display("FAIL reset_scl: got %b want 1", i2c_scl); end
        tests_run++; if (dut.s_reg_q !== 8'h00) begin tests_failed++; $display("FAIL reset_slave_reg: got %h want 00", dut.s_reg_q); end
        rst = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_write_match;
        int busy;
        int stops0;
        stops0 = stop_cnt;
        run_txn(7'h2A, 8'hAA, 1'b0, busy);
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== ACK_CYC) begin tests_failed++; $display("FAIL wr_len: got %0d want %0d", busy, ACK_CYC); end
        tests_run++; if (bits_q.size() !== 19) begin tests_failed++; $display("FAIL wr_bits: got %0d want 19", bits_q.size()); end
        tests_run++; if (get_byte(0) !== 8'h54) begin tests_failed++; $display("FAIL wr_addr_byte: got %h want 54", get_byte(0)); end
        tests_run++; if (get_bit(8) !== 1'b0) begin tests_failed++; $display("FAIL wr_addr_ack: got %b want 0", get_bit(8)); end
        tests_run++; if (get_byte(9) !== 8'hAA) begin tests_failed++; $display("FAIL wr_data_byte: got %h want AA", get_byte(9)); end
        tests_run++; if (get_bit(17) !== 1'b0) begin tests_failed++; $display("FAIL wr_data_ack: got %b want 0", get_bit(17)); end
        tests_run++; if (stop_cnt - stops0 !== 1) begin tests_failed++; $display("FAIL wr_stop: got %0d want 1", stop_cnt - stops0); end
        tests_run++; if (dut.s_reg_q !== 8'hAA) begin tests_failed++; $display("FAIL wr_slave_reg: got %h want AA", dut.s_reg_q); end
        tests_run++; if (data_out !== 8'h00) begin tests_failed++; $display("FAIL wr_data_out: got %h want 00", data_out); end
    endtask

    task automatic test_read_match;
        int busy;
        run_txn(7'h2A, 8'h00, 1'b1, busy);
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== ACK_CYC) begin tests_failed++; $display("FAIL rd_len: got %0d want %0d", busy, ACK_CYC); end
        tests_run++; if (get_byte(0) !== 8'h55) begin tests_failed++; $display("FAIL rd_addr_byte: got %h want 55", get_byte(0)); end
        tests_run++; if (get_bit(8) !== 1'b0) begin tests_failed++; $display("FAIL rd_addr_ack: got %b want 0", get_bit(8)); end
        tests_run++; if (get_byte(9) !== 8'hAA) begin tests_failed++; $display("FAIL rd_bus_byte: got %h want AA", get_byte(9)); end
        tests_run++; if (get_bit(17) !== 1'b1) begin tests_failed++; $display("FAIL rd_master_nack: got %b want 1", get_bit(17)); end
        tests_run++; if (data_out !== 8'hAA) begin tests_failed++; $display("FAIL rd_data_out: got %h want AA", data_out); end
    endtask

    task automatic test_wrong_addr;
        int busy;
        run_txn(7'h55, 8'h55, 1'b0, busy);
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== NACK_CYC) begin tests_failed++; $display("FAIL wwr_len: got %0d want %0d", busy, NACK_CYC); end
        tests_run++; if (bits_q.size() !== 10) begin tests_failed++; $display("FAIL wwr_bits: got %0d want 10", bits_q.size()); end
        tests_run++; if (get_byte(0) !== 8'hAA) begin tests_failed++; $display("FAIL wwr_addr_byte: got %h want AA", get_byte(0)); end
        tests_run++; if (get_bit(8) !== 1'b1) begin tests_failed++; $display("FAIL wwr_nack: got %b want 1", get_bit(8)); end
        tests_run++; if (dut.s_reg_q !== 8'hAA) begin tests_failed++; $display("FAIL wwr_slave_reg: got %h want AA", dut.s_reg_q); end

        run_txn(7'h55, 8'h00, 1'b1, busy);
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== NACK_CYC) begin tests_failed++; $display("FAIL wrd_len: got %0d want %0d", busy, NACK_CYC); end
        tests_run++; if (get_byte(0) !== 8'hAB) begin tests_failed++; $display("FAIL wrd_addr_byte: got %h want AB", get_byte(0)); end
        tests_run++; if (get_bit(8) !== 1'b1) begin tests_failed++; $display("FAIL wrd_nack: got %b want 1", get_bit(8)); end
        tests_run++; if (data_out !== 8'hAA) begin tests_failed++; $display("FAIL wrd_data_out: got %h want AA", data_out); end
    endtask

    task automatic test_reset_mid;
        int busy;
        @(posedge clk); #1;
        addr = 7'h2A; data_in = 8'h3C; rw = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        // 100 clocks in is 12.5 SCL periods, i.e. inside the data byte.
        repeat (100) @(posedge clk);
        #1;
        tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b want 0", ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (i2c_sda !== 1'b1) begin tests_failed++; $display("FAIL mid_sda: got %b want 1", i2c_sda); end
        tests_run++; if (i2c_scl !== 1'b1) begin tests_failed++; $display("FAIL mid_scl: got %b want 1", i2c_scl); end
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL mid_ready: got %b want 1", ready); end
        tests_run++; if (data_out !== 8'h00) begin tests_failed++; $display("FAIL mid_data_out: got %h want 00", data_out); end
        tests_run++; if (dut.s_reg_q !== 8'h00) begin tests_failed++; $display("FAIL mid_slave_reg: got %h want 00", dut.s_reg_q); end
        rst = 1'b1;
        repeat (4) @(posedge clk);

        run_txn(7'h2A, 8'h3C, 1'b0, busy);
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== ACK_CYC) begin tests_failed++; $display("FAIL post_wr_len: got %0d want %0d", busy, ACK_CYC); end
        tests_run++; if (dut.s_reg_q !== 8'h3C) begin tests_failed++; $display("FAIL post_wr_reg: got %h want 3C", dut.s_reg_q); end
        run_txn(7'h2A, 8'h00, 1'b1, busy);
        repeat (2) @(negedge clk);
        tests_run++; if (data_out !== 8'h3C) begin tests_failed++; $display("FAIL post_rd_data_out: got %h want 3C", data_out); end
    endtask

    task automatic test_back_to_back;
        int busy1;
        int busy2;
        int gap;
        int wait_cnt;
        int starts0;
        int late_busy;
        starts0 = start_cnt;
        @(posedge clk); #1;
        addr = 7'h2A; data_in = 8'h5A; rw = 1'b0; enable = 1'b1;
        wait_cnt = 0;
        @(negedge clk);
        while (ready === 1'b1 && wait_cnt < 100) begin
            wait_cnt++;
            @(negedge clk);
        end
        busy1 = 0;
        while (ready === 1'b0 && busy1 < 2000) begin
            busy1++;
            @(negedge clk);
        end
        gap = 0;
        while (ready === 1'b1 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        busy2 = 0;
        while (ready === 1'b0 && busy2 < 2000) begin
            enable = 1'b0;
            busy2++;
            @(negedge clk);
        end
        enable = 1'b0;
        late_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready !== 1'b1) late_busy++;
        end
        tests_run++; if (busy1 !== ACK_CYC) begin tests_failed++; $display("FAIL b2b_len1: got %0d want %0d", busy1, ACK_CYC); end
        tests_run++; if (gap !== 1) begin tests_failed++; $display("FAIL b2b_gap: got %0d want 1", gap); end
        tests_run++; if (busy2 !== ACK_CYC) begin tests_failed++; $display("FAIL b2b_len2: got %0d want %0d", busy2, ACK_CYC); end
        tests_run++; if (start_cnt - starts0 !== 2) begin tests_failed++; $display("FAIL b2b_starts: got %0d want 2", start_cnt - starts0); end
        tests_run++; if (late_busy !== 0) begin tests_failed++; $display("FAIL b2b_no_third: got %0d want 0", late_busy); end
        tests_run++; if (dut.s_reg_q !== 8'h5A) begin tests_failed++; $display("FAIL b2b_slave_reg: got %h want 5A", dut.s_reg_q); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_write_match;
        test_read_match;
        test_wrong_addr;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
